// File: rtl/key_evt_pkg.sv
// Shared types and 50 MHz timing constants for the key event decoder.
package key_evt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT_GAP  = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } key_state_e;

  localparam int KEY_LONG_CYCLES_50M = 50_000_000;
  localparam int KEY_GAP_CYCLES_50M  = 15_000_000;

endpackage

// File: rtl/key_event_decoder.sv
// Turns debounced press/release pulses into short/long/double-click events.
// Double-click detection (WAIT_GAP/PRESS2) is built only when KEY_EVT_DCLICK_EN is defined.
module key_event_decoder
  import key_evt_pkg::*;
#(
  parameter int LONG_CYCLES = KEY_LONG_CYCLES_50M,
  parameter int GAP_CYCLES  = KEY_GAP_CYCLES_50M,
  parameter int CNT_W       = $clog2(((LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES) + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic key_press,
  input  logic key_release,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic long_hold,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_EVT_DCLICK_EN
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`endif

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dclick_q, dclick_d;
  logic             hold_q, busy_q;
  logic             press_s;

  // A simultaneous press and release counts as a release only.
  assign press_s = key_press & ~key_release;

  always_comb begin
    state_d  = state_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    dclick_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press_s) state_d = ST_PRESS1;
        else         state_d = ST_IDLE;
      end
      ST_PRESS1: begin
        if (key_release) begin
`ifdef KEY_EVT_DCLICK_EN
          state_d = ST_WAIT_GAP;
`else
          state_d = ST_IDLE;
          short_d = 1'b1;
`endif
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end else begin
          state_d = ST_PRESS1;
        end
      end
`ifdef KEY_EVT_DCLICK_EN
      ST_WAIT_GAP: begin
        if (press_s) begin
          state_d = ST_PRESS2;
        end else if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          short_d = 1'b1;
        end else begin
          state_d = ST_WAIT_GAP;
        end
      end
      ST_PRESS2: begin
        if (key_release) begin
          state_d  = ST_IDLE;
          dclick_d = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = ST_LONG_HELD;
          long_d  = 1'b1;
        end else begin
          state_d = ST_PRESS2;
        end
      end
`endif
      ST_LONG_HELD: begin
        if (key_release) state_d = ST_IDLE;
        else             state_d = ST_LONG_HELD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Timer only runs in timed states, so it never grows past its terminal value.
  always_comb begin
    cnt_d = '0;
    if (state_d != state_q || state_q == ST_IDLE || state_q == ST_LONG_HELD) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      dclick_q <= 1'b0;
      hold_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      dclick_q <= dclick_d;
      hold_q   <= (state_d == ST_LONG_HELD);
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_click = dclick_q;
  assign long_hold    = hold_q;
  assign busy         = busy_q;

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Classifies debounced push-button activity into single-cycle gesture events: short press, long press and double click, plus a held-long level. Sits downstream of `key_debounce` and consumes its one-cycle press and release edge pulses; its outputs drive UI and mode logic. The button is active-low, so a press corresponds to the debouncer's falling-edge pulse.

## Interface
- `LONG_CYCLES`, default 50_000_000: hold time that makes a press long (1 s at 50 MHz).
- `GAP_CYCLES`, default 15_000_000: maximum release-to-press gap for a double click (300 ms).
- `CNT_W`, default `$clog2(max(LONG_CYCLES,GAP_CYCLES)+1)`: phase-timer width.
- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, asynchronous, active-high.
- `key_press`  in  1  one-cycle pulse at debounced press (debouncer `button_negedge`).
- `key_release`  in  1  one-cycle pulse at debounced release (debouncer `button_posedge`).
- `short_press`  out  1  one-cycle pulse: single short click.
- `long_press`  out  1  one-cycle pulse: hold reached `LONG_CYCLES`.
- `double_click`  out  1  one-cycle pulse: two short clicks within the gap.
- `long_hold`  out  1  level, high while a long press is still held.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, PRESS1, WAIT_GAP, PRESS2, LONG_HELD. The timer `cnt` clears to 0 on every state change and increments each cycle the state is held.
- IDLE: `key_press` goes to PRESS1.
- PRESS1:
  - `key_release` goes to WAIT_GAP.
  - Otherwise, at `cnt == LONG_CYCLES-1`, pulse `long_press` and go to LONG_HELD.
- WAIT_GAP:
  - `key_press` goes to PRESS2.
  - Otherwise, at `cnt == GAP_CYCLES-1`, pulse `short_press` and go to IDLE.
  - A press arriving on the terminal cycle wins: the next state is PRESS2 and no `short_press` is pulsed.
- PRESS2:
  - `key_release` pulses `double_click` and goes to IDLE.
  - At `cnt == LONG_CYCLES-1`, pulse `long_press` and go to LONG_HELD. The first click is discarded.
- LONG_HELD: `long_hold`=1. `key_release` goes to IDLE.
- `key_press` and `key_release` asserted in the same cycle: treat as release only, and ignore the press.
- `key_press` in PRESS1, PRESS2 or LONG_HELD, or `key_release` in IDLE or WAIT_GAP: ignore, with no state change.
- At most one event pulse is asserted in any cycle.

## Timing
- All outputs are registered. Every output resets to 0 and the state resets to IDLE.
- Event pulses are exactly 1 cycle wide.
- Latencies, measured from the cycle the input pulse is sampled:
  - `double_click`: +1 after the second release.
  - `short_press`: +`GAP_CYCLES`+1 after the release.
  - `long_press`: +`LONG_CYCLES`+1 after the press.
  - `long_hold`: rises together with `long_press` and falls 1 cycle after the release.
- `rst` mid-operation: all outputs drop to 0 immediately (asynchronous), pending events are discarded, and no event is emitted after deassertion.
- Timer width: `cnt` never exceeds `max(LONG_CYCLES,GAP_CYCLES)-1`, so there is no wrap.

## Configuration
- Macro `KEY_EVT_DCLICK_EN`.
  - Defined: full behaviour as described above.
  - Undefined:
    - WAIT_GAP and PRESS2 are removed and `double_click` is tied to 0.
    - A release in PRESS1 pulses `short_press` 1 cycle after the release and returns to IDLE.
    - The `GAP_CYCLES` parameter is ignored.

## Structure
- Shared package `key_evt_pkg` holds:
  - the state enum;
  - the default cycle constants for 50 MHz (`KEY_LONG_CYCLES_50M`, `KEY_GAP_CYCLES_50M`).
- Single module with no sub-module. The timer is inline because it is tightly coupled to the state transitions.

## Test plan
All scenarios use `LONG_CYCLES`=100 and `GAP_CYCLES`=40.
- Reset: hold `rst` for 5 cycles, then release. All outputs are 0, `busy`=0, and there are no pulses for 200 idle cycles.
- Short click: press at cycle p, release at p+20. `short_press` is high only at release+41, and no other event occurs.
- Double click: press, release at +10, press 15 cycles later, release 10 cycles after that. `double_click` is pulsed at second release+1, and no `short_press` occurs.
- Long press: press at cycle p, release at p+150. `long_press` is pulsed at p+101, `long_hold` is high from p+101 through the release cycle, then 0 at release+1. No `short_press` occurs.
- Reset mid-gap: press, release, then assert `rst` 20 cycles into WAIT_GAP. Outputs are 0 at once, and no `short_press` ever follows.
- Macro undefined: press, release at +20. `short_press` is pulsed at release+1 and `double_click` stays 0.
